bublesort_job_ctrl: RTL
=======================

// Module: bublesort_job_ctrl
// PURPOSE
//  Host-side sequencer for the bit-serial bubble sort array (N_BITS x K_NUMBERS).
//  Accepts a job as a valid/ready word stream and loads the words into the array stages.
//  Pads short jobs, pulses start, waits for done under a watchdog, then streams the
//  sorted words back out. Sits between the bus/DMA stream and the sort array.
// PARAMETERS
//  N_BITS          8                   word width; must match the sort array
//  K_NUMBERS       49                  array depth; max words per job (>=2)
//  PAD_VALUE       {N_BITS{1'b1}}      fill value for unused stages; sorts to the tail
//  TIMEOUT_CYCLES  65535               SORT-state cycle limit before forced abort
// PORTS
//  clk          in   1          clock; all logic on posedge
//  rst          in   1          async, active-high reset
//  in_valid_i   in   1          input word valid
//  in_ready_o   out  1          input word ready
//  in_data_i    in   N_BITS     input word
//  in_last_i    in   1          last word of job
//  out_valid_o  out  1          sorted word valid
//  out_ready_i  in   1          sorted word accepted
//  out_data_o   out  N_BITS     sorted word, lane order 0..count-1
//  out_last_o   out  1          final sorted word of job
//  load_o       out  K_NUMBERS  one-hot stage load strobe to array
//  writedata_o  out  K*N_BITS   load data to array (word replicated on all lanes)
//  readdata_i   in   K*N_BITS   array contents
//  start_o      out  1          1-cycle sort start pulse
//  done_i       in   1          array all-sorted flag
//  abort_o      out  1          1-cycle abort pulse to array
//  cancel_i     in   1          host cancel request
//  busy_o       out  1          high in every state except IDLE
//  timeout_o    out  1          1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except in_ready_o=1; idx, count and watchdog cleared.
//  States: IDLE, LOAD, PAD, START, GUARD, SORT, DRAIN.
//  IDLE/LOAD: in_ready_o=1. On accept, idx<=idx+1 and count<=count+1. Next cycle,
//   load_o is one-hot at the old idx and writedata_o={K{word}} (both registered, 1-cycle latency).
//   First accept moves IDLE->LOAD.
//  Job end = accept with in_last_i=1, or accept at idx==K-1 (in_last_i ignored there).
//   count==K -> START; otherwise -> PAD. in_ready_o=0 from the cycle after job end.
//  PAD: one stage per cycle, load_o[idx] with PAD_VALUE, until idx==K-1 is written; -> START.
//  START: start_o=1 for exactly 1 cycle, issued after the last load_o pulse; -> GUARD.
//  GUARD: 1 cycle; done_i ignored (it may be stale from the previous job); -> SORT.
//  SORT: watchdog counts cycles. done_i=1 -> DRAIN, idx<=0.
//   Watchdog reaching TIMEOUT_CYCLES -> abort_o and timeout_o pulse together; -> IDLE.
//  DRAIN: out_valid_o=1; out_data_o=readdata_i lane idx; out_last_o=(idx==count-1).
//   Data must hold stable while out_ready_i=0. Accept advances idx; accept with
//   out_last_o -> IDLE. Padding lanes are never output.
//  cancel_i (any non-IDLE state) -> IDLE next cycle; beats done_i and timeout in the same cycle.
//   abort_o pulses only if cancel arrives in START/GUARD/SORT; a partial drain is dropped.
//   cancel_i in IDLE is ignored.
//  Widths: idx/count are $clog2(K_NUMBERS+1) bits. Watchdog is $clog2(TIMEOUT_CYCLES+1)
//   bits and saturates; it clears on entering GUARD.
//  Async rst mid-job returns to IDLE at once. No abort_o is issued; the array has its own reset.
// STRUCTURE
//  Package bublesort_pkg: state encoding localparams; clog2-based width constants.
//  One sub-module: bublesort_watchdog, a saturating counter with clear/enable/expire pulse.
//  The FSM, index/count registers and the output lane mux stay in this module.
// TESTING  (K_NUMBERS=4, N_BITS=8, TIMEOUT_CYCLES=100, bench sorter model ascending)
//  Full job 9,3,7,1 (last on 4th) -> load_o 0001..1000 one per cycle, one start_o,
//   then out 1,3,7,9 with out_last_o on 9.
//  Short job 5,2 (last on 2nd) -> lanes 2,3 loaded with 8'hFF;
//   out 2,5 only, out_last_o on 5.
//  Backpressure: out_ready_i toggling 1/0 during drain -> no word lost or duplicated;
//   out_data_o stable while stalled.
//  done_i held high from the previous job -> ignored in GUARD; no DRAIN until the new
//   job's done_i is seen in SORT.
//  done_i never asserted -> abort_o and timeout_o both 1 cycle, exactly 100 SORT cycles after GUARD;
//   busy_o=0 next cycle.
//  cancel_i in the same cycle as done_i in SORT -> abort_o pulse, IDLE, out_valid_o stays 0.
//  Async rst asserted mid-LOAD -> all outputs at reset values with no clock edge needed.

Source files
------------

// File: rtl/bublesort_pkg.sv
// Shared definitions for the bubble sort job controller.
// Contents:
//   state_t    - controller FSM state encoding
//   cnt_width  - bit width needed to hold values 0..max_val inclusive
package bublesort_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAD   = 3'd2,
        S_START = 3'd3,
        S_GUARD = 3'd4,
        S_SORT  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bublesort_job_ctrl_if.sv
// Bundle of every non-clock signal between the job controller, the host
// stream and the bit-serial sort array.
// Port summary (direction as seen by the controller, modport slave):
//   in_valid_i/in_ready_o/in_data_i/in_last_i     job word input stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o sorted word output stream
//   load_o/writedata_o/readdata_i                 array stage load and readback
//   start_o/done_i/abort_o                        array sort control
//   cancel_i/busy_o/timeout_o                     host control and status
// The master modport is the environment side (host plus array).
//
// Stream handshakes: a word moves on a rising clock edge where valid and ready
// are both high. A source holding valid keeps its data/last stable until the
// transfer; ready may change freely and does not depend on valid.
interface bublesort_job_ctrl_if #(
    parameter int N_BITS    = 8,
    parameter int K_NUMBERS = 49
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [N_BITS-1:0]           in_data_i;
    logic                        in_last_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [N_BITS-1:0]           out_data_o;
    logic                        out_last_o;
    logic [K_NUMBERS-1:0]        load_o;
    logic [K_NUMBERS*N_BITS-1:0] writedata_o;
    logic [K_NUMBERS*N_BITS-1:0] readdata_i;
    logic                        start_o;
    logic                        done_i;
    logic                        abort_o;
    logic                        cancel_i;
    logic                        busy_o;
    logic                        timeout_o;

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, out_ready_i, readdata_i, done_i, cancel_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, load_o, writedata_o,
               start_o, abort_o, busy_o, timeout_o
    );

    modport master (
        output in_valid_i, in_data_i, in_last_i, out_ready_i, readdata_i, done_i, cancel_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, load_o, writedata_o,
               start_o, abort_o, busy_o, timeout_o
    );
endinterface

// File: rtl/bublesort_watchdog.sv
// Saturating cycle counter used to bound the time spent waiting for the array.
// Ports:
//   clk, rst  clock and async active-high reset
//   clr       synchronous clear (wins over en)
//   en        count one cycle
//   expire    combinational pulse during the LIMIT-th enabled cycle after clr
module bublesort_watchdog
    import bublesort_pkg::*;
#(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int             W       = cnt_width(LIMIT);
    localparam logic [W-1:0]   LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0]   LAST_V  = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of enabled cycles already completed, so the
    // LIMIT-th enabled cycle is the one that sees LIMIT-1.
    assign expire = en && !clr && (cnt == LAST_V);

endmodule

// File: rtl/bublesort_job_ctrl.sv
// Host-side sequencer for the bit-serial bubble sort array.
// Takes a job as a word stream, loads each word into its array stage, pads
// unused stages, pulses start, waits for done under a watchdog and streams the
// sorted lanes back out.
// Ports:
//   clk, rst    clock and async active-high reset
//   bus         bublesort_job_ctrl_if.slave (streams, array control, status)
//   dbg_state   current FSM state
module bublesort_job_ctrl
    import bublesort_pkg::*;
#(
    parameter int                N_BITS         = 8,
    parameter int                K_NUMBERS      = 49,
    parameter logic [N_BITS-1:0] PAD_VALUE      = {N_BITS{1'b1}},
    parameter int                TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    bublesort_job_ctrl_if.slave  bus,
    output state_t               dbg_state
);
    localparam int                   IDX_W    = cnt_width(K_NUMBERS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(K_NUMBERS - 1);
    localparam logic [IDX_W-1:0]     FULL_CNT = IDX_W'(K_NUMBERS);
    localparam logic [K_NUMBERS-1:0] LANE0    = K_NUMBERS'(1);

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            idx, idx_nxt;
    logic [IDX_W-1:0]            count, count_nxt;
    logic [K_NUMBERS-1:0]        load_q, load_nxt;
    logic [K_NUMBERS*N_BITS-1:0] wdata_q, wdata_nxt;
    logic                        start_q, start_nxt;

    logic              in_ready, in_fire, out_valid, out_fire, lane_last;
    logic              cancel_hit, wd_clr, wd_en, wd_expire;
    logic [N_BITS-1:0] lane_data;

    assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
    assign in_fire    = bus.in_valid_i && in_ready;
    assign out_valid  = (state == S_DRAIN);
    assign lane_last  = out_valid && (idx == count - 1'b1);
    assign out_fire   = out_valid && bus.out_ready_i;
    assign cancel_hit = bus.cancel_i && (state != S_IDLE);

    // Cleared for the whole GUARD cycle, so the first SORT cycle counts from zero.
    assign wd_clr = (state == S_GUARD);
    assign wd_en  = (state == S_SORT);

    bublesort_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Output lane select; only lanes below count are ever presented.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < K_NUMBERS; i++) begin
            if (idx == IDX_W'(i)) begin
                lane_data = bus.readdata_i[i*N_BITS +: N_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            count   <= '0;
            load_q  <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            count   <= count_nxt;
            load_q  <= load_nxt;
            wdata_q <= wdata_nxt;
            start_q <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        count_nxt = count;
        load_nxt  = '0;
        wdata_nxt = wdata_q;
        start_nxt = 1'b0;

        case (state)
            S_IDLE, S_LOAD: begin
                if (in_fire) begin
                    load_nxt  = LANE0 << idx;
                    wdata_nxt = {K_NUMBERS{bus.in_data_i}};
                    idx_nxt   = idx + 1'b1;
                    count_nxt = count + 1'b1;
                    // The last stage ends the job whatever in_last_i says.
                    if (bus.in_last_i || (idx == LAST_IDX)) begin
                        state_nxt = ((count + 1'b1) == FULL_CNT) ? S_START : S_PAD;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_PAD: begin
                load_nxt  = LANE0 << idx;
                wdata_nxt = {K_NUMBERS{PAD_VALUE}};
                idx_nxt   = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // start_o is registered so it trails the final load strobe by a cycle.
                start_nxt = 1'b1;
                state_nxt = S_GUARD;
            end
            S_GUARD: begin
                // done_i may still be high from the previous job here.
                state_nxt = S_SORT;
            end
            S_SORT: begin
                if (wd_expire) begin
                    state_nxt = S_IDLE;
                end else if (bus.done_i) begin
                    state_nxt = S_DRAIN;
                    idx_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    idx_nxt = idx + 1'b1;
                    if (lane_last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Cancel overrides everything, including done and watchdog expiry, and
        // suppresses any load or start that would otherwise land in IDLE.
        if (cancel_hit) begin
            state_nxt = S_IDLE;
            load_nxt  = '0;
            start_nxt = 1'b0;
        end

        if (state_nxt == S_IDLE) begin
            idx_nxt   = '0;
            count_nxt = '0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? lane_data : '0;
    assign bus.out_last_o  = lane_last;
    assign bus.load_o      = load_q;
    assign bus.writedata_o = wdata_q;
    assign bus.start_o     = start_q;
    assign bus.abort_o     = (bus.cancel_i && ((state == S_START) || (state == S_GUARD) ||
                                               (state == S_SORT))) || wd_expire;
    assign bus.timeout_o   = wd_expire && !bus.cancel_i;
    assign bus.busy_o      = (state != S_IDLE);
    assign dbg_state       = state;

endmodule
